s_cska_pipe: RTL and testbench
==============================

# s_cska_pipe

Parametrised, pipelined signed carry-skip adder/subtractor with valid/ready handshake. Operands of WIDTH bits are split into skip blocks of BLOCK bits, with one pipeline register after each block, so throughput is one operation per cycle at any WIDTH. It is the registered, width-generic successor to the flat 4-bit signed carry-skip adder. It feeds accumulator and MAC datapaths that need a closed timing path per block.

## Interface
- WIDTH, 16: operand width in bits. Must be a multiple of BLOCK and at least 4.
- BLOCK, 4: skip-block width in bits, at least 2. The number of pipeline stages is NBLK = WIDTH/BLOCK.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  an operand set is presented.
- in_ready  out  1  the block accepts the operand set this cycle.
- a  in  WIDTH  signed operand A (two's complement).
- b  in  WIDTH  signed operand B (two's complement).
- cin  in  1  carry-in for add, borrow-in for subtract.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  out_sum is valid.
- out_ready  in  1  the consumer accepts out_sum.
- out_sum  out  WIDTH+1  signed result, sign-correct with no overflow possible.

## Operation
- Result:
  - sub=0: out_sum = a + b + cin.
  - sub=1: out_sum = a − b − cin.
- Implementation: the adder uses b' = b ^ {WIDTH{sub}} and carry-in c0 = cin ^ sub.
- The MSB of out_sum is a[WIDTH-1] ^ b'[WIDTH-1] ^ c_out, which is the exact signed (WIDTH+1)-bit result.
- Stage k (k = 0..NBLK-1) handles bits [k·BLOCK +: BLOCK]:
  - Ripple sum: s_i = p_i ^ c_i, with p_i = a_i ^ b'_i and g_i = a_i & b'_i.
  - Block carry-out = (AND of all p_i in the block) ? block carry-in : ripple carry-out.
  - This is a true skip mux, not the AND-with-NOT variant.
- Each stage register holds:
  - valid bit;
  - sum bits already computed (low k·BLOCK bits plus the current block);
  - the unprocessed upper a and b' bits;
  - the outgoing block carry;
  - the MSB-pair XOR (a[WIDTH-1] ^ b'[WIDTH-1]), captured at stage 0.
- The last stage register drives out_sum and out_valid.
- Stage k advances when it is empty or stage k+1 advances. The last stage advances when it is empty or out_ready is 1.
- in_ready = (stage 0 empty) OR (stage 0 advances). It is purely combinational from registered state and out_ready, with no combinational path from in_valid.
- A transfer occurs on in_valid & in_ready at the input and on out_valid & out_ready at the output.
- Data registers load only on advance. Stalled stages hold all contents.

## Timing
- Latency: NBLK cycles from the input transfer edge to out_valid=1 with no backpressure. With WIDTH=8 and BLOCK=4, latency is 2.
- Throughput: one transfer per cycle when out_ready is held at 1.
- Reset (rst_n low, asynchronous):
  - All valid bits clear immediately, so out_valid=0.
  - out_sum=0 and all data registers clear.
  - in_ready reads 1 while all stages are empty.
  - Operations in flight are discarded.
- Release of rst_n is synchronised externally. The first transfer can happen on the first rising edge after release.
- Full pipeline with out_ready=0: in_ready=0. No data changes or is lost, and out_sum is stable while out_valid=1 and out_ready=0.
- If out_ready rises while the pipe is full: in the same cycle all stages advance, in_ready=1, and a new input is accepted with no bubble.
- Simultaneous input and output transfer on a full pipe keeps occupancy at NBLK.
- Results leave in acceptance order.

## Test plan
- WIDTH=8, BLOCK=4: a=0x7F, b=0x01, cin=0, sub=0 → after 2 cycles out_valid=1, out_sum=0x080 (+128). Then a=0x80, b=0xFF → out_sum=0x17F (−129).
- Subtract: a=5, b=7, sub=1, cin=0 → out_sum=0x1FE (−2). With cin=1 → 0x1FD (−3).
- Full skip path: a=0x55, b=0xAA, cin=1, sub=0 → both blocks fully propagate and out_sum=0x000. Repeat with cin=0 → 0x1FF (−1).
- Backpressure: stream 6 back-to-back random operands while out_ready toggles 1,0,0,1,…. Required:
  - in_ready=0 exactly when both stages are full and out_ready=0;
  - results match a golden model, in order, with no drops or duplicates.
- Reset mid-flight: 2 operations in the pipe, assert rst_n=0 between edges → out_valid falls immediately and out_sum=0. After release, no stale result appears and the next operand (3+4) returns 0x007 after 2 cycles.
- Sweep WIDTH∈{4,16,32} with BLOCK∈{2,4,8} (divisible combinations only): 10k random operands at full throughput, checked against the exact signed (WIDTH+1)-bit sum or difference, with latency = WIDTH/BLOCK.

Source files
------------

// File: rtl/s_cska_pipe.sv
// s_cska_pipe -- pipelined signed carry-skip adder/subtractor.
//
// The operands are split into NBLK = WIDTH/BLOCK skip blocks. Stage k
// resolves bits [k*BLOCK +: BLOCK] and registers them. The block's carry is
// registered alongside, and so are the still-unprocessed upper operand bits.
// A valid/ready handshake with per-stage advance gives one result per cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand set presented
//   in_ready   out  operand set accepted this cycle
//   a, b       in   WIDTH-bit two's-complement operands
//   cin        in   carry-in (add) / borrow-in (subtract)
//   sub        in   0 = a + b + cin, 1 = a - b - cin
//   out_valid  out  out_sum holds a result
//   out_ready  in   consumer takes out_sum
//   out_sum    out  WIDTH+1-bit exact signed result
module s_cska_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  localparam int NBLK = WIDTH / BLOCK;

  logic [NBLK-1:0]  vld_q;
  logic [NBLK-1:0]  adv;
  logic [WIDTH-1:0] bp0;

  // Subtraction is a + ~b + 1; a borrow-in cancels that +1.
  assign bp0 = b ^ {WIDTH{sub}};

  // A stage moves when it is empty or its successor moves. The chain ends
  // at out_ready, so in_ready never depends on in_valid.
  always_comb begin
    adv = '0;
    adv[NBLK-1] = ~vld_q[NBLK-1] | out_ready;
    for (int k = NBLK - 2; k >= 0; k--) begin
      adv[k] = ~vld_q[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      if (adv[0]) vld_q[0] <= in_valid;
      for (int k = 1; k < NBLK; k++) begin
        if (adv[k]) vld_q[k] <= vld_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    localparam int REM = WIDTH - k * BLOCK;  // operand bits entering stage k
    localparam int SW  = (k + 1) * BLOCK;    // sum bits known after stage k

    logic [REM-1:0]   a_in;
    logic [REM-1:0]   bp_in;
    logic             c_in;
    logic             x_in;
    logic [BLOCK-1:0] blk_s;
    logic             rc;
    logic             allp;
    logic             p;
    logic             c_d;
    logic [SW-1:0]    sum_d;
    logic [SW-1:0]    sum_q;
    logic             c_q;
    logic             x_q;

    if (k == 0) begin : g_src
      assign a_in  = a;
      assign bp_in = bp0;
      assign c_in  = cin ^ sub;
      // The sign of the widened result needs only this XOR and the final carry.
      assign x_in  = a[WIDTH-1] ^ bp0[WIDTH-1];
      assign sum_d = blk_s;
    end else begin : g_src
      assign a_in  = g_stg[k-1].g_rem.a_q;
      assign bp_in = g_stg[k-1].g_rem.bp_q;
      assign c_in  = g_stg[k-1].c_q;
      assign x_in  = g_stg[k-1].x_q;
      assign sum_d = {blk_s, g_stg[k-1].sum_q};
    end

    // Ripple through the block, then take the skip mux for the carry-out.
    // When every propagate bit is set, the ripple carry-out equals the
    // block carry-in anyway. The mux cuts that long path out of the timing.
    always_comb begin
      blk_s = '0;
      rc    = c_in;
      allp  = 1'b1;
      p     = 1'b0;
      c_d   = 1'b0;
      for (int j = 0; j < BLOCK; j++) begin
        p        = a_in[j] ^ bp_in[j];
        blk_s[j] = p ^ rc;
        rc       = (a_in[j] & bp_in[j]) | (p & rc);
        allp     = allp & p;
      end
      c_d = allp ? c_in : rc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
        x_q   <= 1'b0;
      end else if (adv[k]) begin
        sum_q <= sum_d;
        c_q   <= c_d;
        x_q   <= x_in;
      end
    end

    if (REM > BLOCK) begin : g_rem
      logic [REM-BLOCK-1:0] a_q;
      logic [REM-BLOCK-1:0] bp_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bp_q <= '0;
        end else if (adv[k]) begin
          a_q  <= a_in[REM-1:BLOCK];
          bp_q <= bp_in[REM-1:BLOCK];
        end
      end
    end
  end

  assign out_valid = vld_q[NBLK-1];
  assign out_sum   = {g_stg[NBLK-1].x_q ^ g_stg[NBLK-1].c_q, g_stg[NBLK-1].sum_q};

endmodule

// File: tb/tb_s_cska_pipe.sv
// Bench for s_cska_pipe: a WIDTH=8/BLOCK=4 instance gets directed, backpressure
// and reset cases. A WIDTH=16/BLOCK=2 instance streams random operands at
// full rate. Expected sums are queued on input transfer and compared on
// output transfer.
module tb_s_cska_pipe;
  localparam int W   = 8;
  localparam int B   = 4;
  localparam int NB  = W / B;
  localparam int W2  = 16;
  localparam int B2  = 2;
  localparam int NB2 = W2 / B2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [W-1:0] a, b;
  logic [W:0]   out_sum;
  logic [W:0]   cur_exp;

  logic          in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2;
  logic [W2-1:0] a2, b2;
  logic [W2:0]   out_sum2;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_lat = 1'b1;

  typedef struct {logic [W:0] v; int t;} ent_t;
  typedef struct {logic [W2:0] v; int t;} ent2_t;
  ent_t  q[$];
  ent2_t q2[$];
  bit [NB-1:0] mvld;

  s_cska_pipe #(.WIDTH(W), .BLOCK(B)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum));

  s_cska_pipe #(.WIDTH(W2), .BLOCK(B2)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_sum(out_sum2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [W:0] gold(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic c, input logic s);
    logic [W:0] xe, ye;
    xe = {x[W-1], x};
    ye = {y[W-1], y};
    return s ? (xe - ye - {{W{1'b0}}, c}) : (xe + ye + {{W{1'b0}}, c});
  endfunction

  function automatic logic [W2:0] gold2(input logic [W2-1:0] x, input logic [W2-1:0] y,
                                        input logic c, input logic s);
    logic [W2:0] xe, ye;
    xe = {x[W2-1], x};
    ye = {y[W2-1], y};
    return s ? (xe - ye - {{W2{1'b0}}, c}) : (xe + ye + {{W2{1'b0}}, c});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the narrow instance, sampled mid-cycle ahead of the next edge.
  always @(negedge clk) begin : mon
    bit [NB-1:0] madv;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      mvld = '0;
    end else begin
      check("in_ready", in_ready, !(&mvld) || out_ready);
      check("out_valid", out_valid, mvld[NB-1]);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("sum", out_sum, e.v);
          if (chk_lat) check("latency", cyc - e.t, NB);
        end
      end
      if (in_valid && in_ready) q.push_back('{cur_exp, cyc});
      madv[NB-1] = !mvld[NB-1] || out_ready;
      for (int k = NB - 2; k >= 0; k--) madv[k] = !mvld[k] || madv[k+1];
      for (int k = NB - 1; k >= 1; k--) if (madv[k]) mvld[k] = mvld[k-1];
      if (madv[0]) mvld[0] = in_valid;
    end
  end

  always @(negedge clk) begin : mon2
    ent2_t e;
    if (!rst_n) begin
      q2.delete();
    end else begin
      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) begin
          check("wide_unexpected_out", out_valid2, 1'b0);
        end else begin
          e = q2.pop_front();
          check("wide_sum", out_sum2, e.v);
          check("wide_latency", cyc - e.t, NB2);
        end
      end
      if (in_valid2) check("wide_in_ready", in_ready2, 1'b1);
      if (in_valid2 && in_ready2) q2.push_back('{gold2(a2, b2, cin2, sub2), cyc});
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s, input logic [W:0] e);
    bit acc = 1'b0;
    a = x; b = y; cin = c; sub = s; cur_exp = e; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("drive_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drive_rand();
    logic [W-1:0] x, y;
    logic c, s;
    x = W'($urandom());
    y = W'($urandom());
    c = 1'($urandom());
    s = 1'($urandom());
    drive(x, y, c, s, gold(x, y, c, s));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 1; cur_exp = '0;
    in_valid2 = 0; a2 = '0; b2 = '0; cin2 = 0; sub2 = 0; out_ready2 = 1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, '0);
    check("rst_in_ready", in_ready, 1'b1);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // +127 + 1 with explicit two-cycle latency.
    drive(8'h7F, 8'h01, 1'b0, 1'b0, 9'h080);
    check("lat_edge1_valid", out_valid, 1'b0);
    idle(1);
    check("lat_edge2_valid", out_valid, 1'b1);
    check("sum_7f_plus_1", out_sum, 9'h080);
    idle(3);

    // Directed cases streamed back to back.
    drive(8'h80, 8'hFF, 1'b0, 1'b0, 9'h17F);
    drive(8'h05, 8'h07, 1'b0, 1'b1, 9'h1FE);
    drive(8'h05, 8'h07, 1'b1, 1'b1, 9'h1FD);
    drive(8'h55, 8'hAA, 1'b1, 1'b0, 9'h000);
    drive(8'h55, 8'hAA, 1'b0, 1'b0, 9'h1FF);
    idle(4);

    // Backpressure: out_ready follows 1,0,0,1,... while six operands stream.
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) drive_rand();
      end
      begin
        for (int i = 0; i < 24; i++) begin
          out_ready = (i % 3) == 0;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    // Long stall to fill the pipe, then release while it is full.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) drive_rand();
      end
      begin
        idle(6);
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("bp_drained", q.size(), 0);
    chk_lat = 1'b1;

    // Reset with two operations in flight.
    drive(8'h11, 8'h22, 1'b0, 1'b0, 9'h033);
    drive(8'h33, 8'h44, 1'b0, 1'b0, 9'h077);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_sum", out_sum, '0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(8'd3, 8'd4, 1'b0, 1'b0, 9'h007);
    check("post_rst_edge1", out_valid, 1'b0);
    idle(1);
    check("post_rst_edge2", out_valid, 1'b1);
    check("post_rst_sum", out_sum, 9'h007);
    idle(4);
    check("main_drained", q.size(), 0);

    // Wide instance: random operands at full throughput.
    in_valid2 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a2 = W2'($urandom());
      b2 = W2'($urandom());
      cin2 = 1'($urandom());
      sub2 = 1'($urandom());
      if (i == 0) begin a2 = 16'h5555; b2 = 16'hAAAA; cin2 = 1'b1; sub2 = 1'b0; end
      if (i == 1) begin a2 = 16'h8000; b2 = 16'h7FFF; cin2 = 1'b1; sub2 = 1'b1; end
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    idle(NB2 + 3);
    check("wide_drained", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule
